tia_d1_biphase: RTL and testbench
=================================

# tia_d1_biphase

Two-phase clock generator plus one D1 delay stage for the TIA horizontal-timing chain. A single master clock produces non-overlapping phases `phi1`/`phi2`, each one `clk` period wide, repeating every 4 `clk` periods. The D1 stage is a master/slave shift cell: it samples `in` during `phi1` and presents it on `out` at the start of `phi2`. It also provides an inverted master tap.

## Interface
- No parameters.
- `clk`  input  1  master (colour) clock; all state updates on rising edge.
- `r`  input  1  reset; asynchronous, active-high.
- `in`  input  1  D1 data input; may change at any time except within setup of the sampling edge.
- `phi1`  output  1  phase-1 clock, registered, high 1 `clk` period in 4.
- `phi2`  output  1  phase-2 clock, registered, high 1 `clk` period in 4, never overlapping `phi1`.
- `rl`  output  1  latched reset; extends `r` through the first `phi2` pulse after release.
- `tap`  output  1  inverted master-latch value (`~m`).
- `out`  output  1  D1 slave output.

## Operation
- 2-bit phase register `ph` cycles P0→P1→P2→P3→P0, one step per `clk` edge.
  - P0: `phi1`=1, `phi2`=0.
  - P1: both 0.
  - P2: `phi1`=0, `phi2`=1.
  - P3: both 0.
- `phi1`/`phi2` are registered flops updated on the same edge as `ph`, with no combinational decode glitches.
- Master latch `m`: on the edge leaving P0 (end of `phi1`), `m <= in`.
- Slave `out`: on the edge entering P2 (start of `phi2`), `out <= m`.
- `tap = ~m`, combinational from the `m` flop.
- `rl` behaviour:
  - Set asynchronously while `r`=1.
  - After release, stays 1 until the edge leaving P2, i.e. the end of the first `phi2` pulse, then clears.
  - Stays 0 thereafter.
- Reset values while `r`=1: `ph`=P3, `phi1`=0, `phi2`=0, `m`=0, `tap`=1, `out`=0, `rl`=1.
- Reset asserted mid-cycle forces all reset values immediately; `in` is ignored during reset.

## Timing
- First `clk` edge after `r` deasserts: `ph`→P0 and `phi1` rises.
- Edge 2: `phi1` falls and `m` captures `in`. `tap` is valid immediately after this edge.
- Edge 3: `phi2` rises and `out` updates.
- Edge 4: `phi2` falls. `rl` clears on this first post-reset cycle.
- Edge 5: `phi1` rises again.
- Latency:
  - `in` sampled at the end of `phi1` reaches `out` one `clk` later, at the `phi2` rising edge.
  - `in` changed at the `phi1` rising edge appears on `out` at the same cycle's `phi2` rise.
- Full cycle = 4 `clk`. `out` and `tap` hold for 4 `clk` between updates.
- `in` must be stable for setup/hold around the edge leaving P0. Changes at any other time have no effect until the next `phi1` window.
- After reset, `out`/`tap` are not refreshed until edges 2 and 3, and hold their reset values before then.

## Test plan
- Reset then free-run:
  - `r`=1 for 3 `clk` → `phi1`=`phi2`=0, `out`=0, `tap`=1, `rl`=1.
  - Release → `phi1` high on edge 1, `phi2` high on edge 3, period 4 `clk`, never overlapping; `rl` falls on edge 4.
- Single pulse: drive `in`=1 at a `phi1` rise, `in`=0 at the next `phi1` rise.
  - After the first `phi2` rise: `out`=1, `tap`=0.
  - After the next `phi2` rise: `out`=0, `tap`=1.
- Held value: `in`=1 for 2 cycles, then 0 for 2 cycles → `out`/`tap` = 1/0, 1/0, 0/1, 0/1 at successive `phi2` rises.
- Off-window change: toggle `in` during P2/P3 only, restoring it before P0 ends → `out` unchanged.
- Mid-operation reset: assert `r` during a `phi2` pulse with `out`=1 → `phi2`=0, `out`=0, `tap`=1, `rl`=1 asynchronously. Normal sequence resumes from P0 after release.
- Tap/out consistency: random `in` per cycle for 200 cycles → at every `phi2` rise, `out` equals the `in` sampled at the prior `phi1` end, and `tap` equals `~out`.

Source files
------------

// File: rtl/tia_d1_biphase.sv
// Two-phase non-overlapping clock generator (phi1/phi2, period 4 clk) with one
// D1 master/slave delay cell and an inverted master tap for the TIA timing chain.
module tia_d1_biphase (
    input  logic clk,
    input  logic r,
    input  logic in,
    output logic phi1,
    output logic phi2,
    output logic rl,
    output logic tap,
    output logic out
);

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    phase_t ph;
    phase_t ph_next;
    logic   m;

    always_comb begin
        // NOTE: default assignment first so no path leaves ph_next unassigned (no latch).
        ph_next = P0;
        case (ph)
            P0: ph_next = P1;
            P1: ph_next = P2;
            P2: ph_next = P3;
            P3: ph_next = P0;
            default: ph_next = P0;
        endcase
    end

    // Phases are decoded from ph_next so phi1/phi2 come straight off flops,
    // changing on the same edge as ph with no decode glitches.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            // NOTE: non-blocking assignments for all sequential state.
            ph   <= P3;
            phi1 <= 1'b0;
            phi2 <= 1'b0;
            m    <= 1'b0;
            out  <= 1'b0;
            rl   <= 1'b1;
        end else begin
            ph   <= ph_next;
            phi1 <= (ph_next == P0);
            phi2 <= (ph_next == P2);
            if (ph == P0) m   <= in;
            if (ph == P1) out <= m;
            // rl covers the first full phi1/phi2 cycle after release, then stays low.
            if (ph == P2) rl  <= 1'b0;
        end
    end

    assign tap = ~m;

endmodule

// File: tb/tb_tia_d1_biphase.sv
// Self-checking bench for tia_d1_biphase: directed phases plus random data,
// compared against an edge-count model of the biphase/D1 behaviour.
module tb_tia_d1_biphase;

    logic clk = 1'b0;
    logic r   = 1'b1;
    logic in  = 1'b0;
    logic phi1, phi2, rl, tap, out;

    int vectors     = 0;
    int miscompares = 0;

    // Model: k counts clock edges since reset release (0 while in reset).
    int   k     = 0;
    logic exp_m = 1'b0;
    logic exp_o = 1'b0;

    tia_d1_biphase dut (
        .clk (clk),
        .r   (r),
        .in  (in),
        .phi1(phi1),
        .phi2(phi2),
        .rl  (rl),
        .tap (tap),
        .out (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".phi1"}, phi1, (k % 4 == 1));
        chk({tag, ".phi2"}, phi2, (k % 4 == 3));
        chk({tag, ".rl"},   rl,   (k < 4));
        chk({tag, ".out"},  out,  exp_o);
        chk({tag, ".tap"},  tap,  ~exp_m);
    endtask

    // One clock edge: model updates from the input values present at the edge,
    // then outputs are sampled 1 time unit after the edge.
    task automatic step(input string tag);
        logic in_at_edge;
        logic r_at_edge;
        in_at_edge = in;
        r_at_edge  = r;
        @(posedge clk);
        #1;
        if (r_at_edge) begin
            k = 0; exp_m = 1'b0; exp_o = 1'b0;
        end else begin
            k++;
            if (k % 4 == 2) exp_m = in_at_edge;  // end of phi1: master samples in
            if (k % 4 == 3) exp_o = exp_m;       // start of phi2: slave updates
        end
        check_all(tag);
    endtask

    task automatic run_to(input int phase, input string tag);
        for (int i = 0; i < 4; i++) begin
            if (k % 4 == phase && k != 0) break;
            step(tag);
        end
    endtask

    initial begin
        // Reset held for 3 clocks.
        r = 1'b1; in = 1'b0;
        for (int i = 0; i < 3; i++) step("reset");

        // Release and free-run.
        r = 1'b0;
        for (int i = 0; i < 8; i++) step("freerun");

        // Single pulse: in=1 at one phi1 rise, back to 0 at the next.
        run_to(1, "align");
        in = 1'b1;
        run_to(3, "pulse_a");
        chk("pulse_out1", out, 1'b1);
        chk("pulse_tap0", tap, 1'b0);
        run_to(1, "pulse_b");
        in = 1'b0;
        run_to(3, "pulse_c");
        chk("pulse_out0", out, 1'b0);
        chk("pulse_tap1", tap, 1'b1);

        // Held value: 1 for two cycles, then 0 for two cycles.
        run_to(1, "align");
        in = 1'b1;
        for (int i = 0; i < 8; i++) step("held1");
        in = 1'b0;
        for (int i = 0; i < 8; i++) step("held0");

        // Off-window change: toggle during P2/P3, restore before P0 ends.
        run_to(3, "align");
        in = 1'b1;
        step("offwin_p2");
        in = 1'b0;
        step("offwin_p3");
        for (int i = 0; i < 4; i++) step("offwin_after");
        chk("offwin_out", out, 1'b0);

        // Mid-operation reset during a phi2 pulse with out=1.
        run_to(1, "align");
        in = 1'b1;
        run_to(3, "prereset");
        chk("prereset_out", out, 1'b1);
        #2;
        r = 1'b1;
        #1;
        k = 0; exp_m = 1'b0; exp_o = 1'b0;
        check_all("async_reset");
        in = 1'b0;
        step("midreset_a");
        step("midreset_b");
        r = 1'b0;
        for (int i = 0; i < 8; i++) step("resume");

        // Random data, changed after every edge so off-window changes are covered too.
        for (int i = 0; i < 800; i++) begin
            in = 1'($urandom_range(0, 1));
            step("random");
            if (k % 4 == 3) chk("random_tap_vs_out", tap, ~out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
